multdiv_ctrl: RTL
=================

Name: multdiv_ctrl

Overview:
Issue and interlock controller that sits between the execute stage and the shared iterative multiply/divide unit. It accepts one mult or div request at a time, latches operands and destination register, and pulses the unit's one-cycle start control. It stalls the pipeline until the unit reports ready, then presents a one-cycle writeback to the register file. A watchdog and a pipeline-flush abort cover lost or squashed operations.

Parameters:
TIMEOUT, 48, BUSY cycles allowed before the watchdog forces completion (must exceed the 33-cycle mult latency)
CNT_W, 6, width of the watchdog counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start_mult  in  1  execute stage requests multiply (level, sampled in IDLE)
start_div  in  1  execute stage requests divide
opA  in  32  operand A (dividend / multiplier)
opB  in  32  operand B (divisor / multiplicand)
rd  in  5  destination register of the request
kill  in  1  pipeline flush; abandons an in-flight operation
md_operandA  out  32  held operand A to multdiv unit
md_operandB  out  32  held operand B to multdiv unit
md_ctrl_MULT  out  1  one-cycle multiply start pulse
md_ctrl_DIV  out  1  one-cycle divide start pulse
md_result  in  32  unit result
md_exception  in  1  unit exception (e.g. divide by zero)
md_resultRDY  in  1  unit ready
stall  out  1  freeze fetch/decode/execute
wb_valid  out  1  one-cycle register-file write strobe
wb_rd  out  5  writeback destination
wb_data  out  32  writeback data
wb_exception  out  1  writeback carries an exception (unit or watchdog)

Behaviour:
- States: IDLE, START, BUSY, DONE. Reset is synchronous to clock: state=IDLE; all registered outputs, latched operands, op, rd and counter = 0.
- IDLE: if start_mult|start_div, latch opA/opB/rd/op and go to START. If both are asserted, multiply wins.
- START: assert exactly one of md_ctrl_MULT/md_ctrl_DIV for this single cycle, clear the counter, then go to BUSY.
- md_operandA/B are driven from the latches, stable from START until the next accept.
- BUSY: counter increments each cycle.
  - md_resultRDY=1: capture md_result/md_exception, go to DONE.
  - Otherwise, counter==TIMEOUT-1: capture data=0, exception=1, go to DONE.
  - md_resultRDY is ignored in the START cycle.
- DONE: wb_valid=1 for exactly one cycle, with wb_rd/wb_data/wb_exception from the captures, then go to IDLE.
  - If rd==0 and no exception, wb_valid stays 0.
  - wb_data/wb_rd/wb_exception are 0 whenever wb_valid=0.
- stall = (IDLE & (start_mult|start_div)) | START | BUSY. It is combinational and deasserts in DONE, so the dependent instruction may issue the cycle after writeback.
- A new request is accepted only in IDLE. Requests presented in DONE wait one cycle, with stall held low that cycle.
- kill in START or BUSY: go to IDLE next cycle with no writeback; md_ctrl pulses are still limited to one cycle. The unit may run on; the next START re-pulses its control, which restarts it.
- kill in DONE or IDLE is ignored.
- reset mid-operation: IDLE next cycle, no writeback.
- Latency, accept to wb_valid: 2 + N cycles, where N is the BUSY cycles up to and including the cycle in which md_resultRDY is seen.

Decomposition:
- Shared package holds:
  - state encoding localparams S_IDLE=2'd0, S_START=2'd1, S_BUSY=2'd2, S_DONE=2'd3
  - OP_MULT=1'b0, OP_DIV=1'b1
- Operand/rd/op latches use the existing dffe_ref register.
- The watchdog counter is one natural sub-module, md_watchdog: clock, reset, clr, en, count, expired.

Test Plan:
- Reset check: after reset, all outputs 0 and state IDLE. Stimulus: start_mult, opA=6, opB=7, rd=5; unit model asserts RDY 33 cycles after the pulse. Required: md_ctrl_MULT high exactly one cycle; stall high through BUSY; wb_valid one cycle with wb_rd=5, wb_data=42, wb_exception=0.
- start_div, opA=100, opB=0, rd=3; model returns RDY with md_exception=1 -> wb_valid=1, wb_rd=3, wb_exception=1.
- start_mult with the model never asserting RDY -> exactly TIMEOUT BUSY cycles, then wb_valid=1, wb_data=0, wb_exception=1.
- kill asserted on the 10th BUSY cycle -> IDLE next cycle, no wb_valid. An immediate new div then completes correctly, with a fresh md_ctrl_DIV pulse.
- Back-to-back mult then div (requests held) -> second accept one cycle after the first DONE; both writebacks correct and in order.
- start_mult and start_div asserted together -> only md_ctrl_MULT pulses. Separately, mult with rd=0 and no exception -> wb_valid never asserted.

Source files
------------

// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller: state
// encoding, operation codes and the result-capture record.
package multdiv_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Result captured at the end of BUSY and replayed during DONE.
  typedef struct packed {
    logic [31:0] data;
    logic        exc;
  } md_capture_t;

endpackage

// File: rtl/dffe_ref.sv
// Enabled D register with synchronous active-high reset. It is used for the
// operand, destination and opcode latches of the controller.
module dffe_ref #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic bit_reg;

      // One flop per bit: clear on reset, load when enabled, else hold.
      always_ff @(posedge clock) begin
        if (reset) begin
          bit_reg <= 1'b0;
        end else if (en) begin
          bit_reg <= d[gi];
        end
      end

      assign q[gi] = bit_reg;
    end
  endgenerate

endmodule

// File: rtl/md_watchdog.sv
// Cycle counter guarding the BUSY state. It is cleared while the unit is
// being started and counts BUSY cycles; expired flags the last allowed one.
module md_watchdog
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  // Clear has priority over counting so every operation starts from zero.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count   = count_reg;
  // count is 0 in the first BUSY cycle, so this fires in BUSY cycle TIMEOUT.
  assign expired = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/interlock controller between the execute stage and the shared
// iterative multiply/divide unit. It accepts one request at a time, pulses
// the unit start control, stalls the pipeline until the unit is ready (or the
// watchdog expires) and then presents a one-cycle register-file writeback.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [4:0]  rd,
  input  logic        kill,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  logic [1:0]       state_reg, state_next;
  md_capture_t      cap_reg, cap_next;
  logic             req, accept, op_in;
  logic             in_idle, in_start, in_busy, in_done, wb_fire;
  logic [31:0]      opa_q, opb_q;
  logic [4:0]       rd_q;
  logic             op_q;
  logic             wd_expired;
  // The raw count is only useful for debug probing; control uses expired.
  logic [CNT_W-1:0] wd_count_unused;

  assign req      = start_mult | start_div;
  assign in_idle  = (state_reg == S_IDLE);
  assign in_start = (state_reg == S_START);
  assign in_busy  = (state_reg == S_BUSY);
  assign in_done  = (state_reg == S_DONE);
  assign accept   = in_idle & req;
  // Multiply wins when both requests are raised together.
  assign op_in    = start_mult ? OP_MULT : OP_DIV;

  dffe_ref #(.W(32)) u_opa_latch (
    .clock(clock), .reset(reset), .en(accept), .d(opA), .q(opa_q)
  );

  dffe_ref #(.W(32)) u_opb_latch (
    .clock(clock), .reset(reset), .en(accept), .d(opB), .q(opb_q)
  );

  dffe_ref #(.W(5)) u_rd_latch (
    .clock(clock), .reset(reset), .en(accept), .d(rd), .q(rd_q)
  );

  dffe_ref #(.W(1)) u_op_latch (
    .clock(clock), .reset(reset), .en(accept), .d(op_in), .q(op_q)
  );

  md_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clr     (in_start),
    .en      (in_busy),
    .count   (wd_count_unused),
    .expired (wd_expired)
  );

  // State and result-capture registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cap_reg   <= cap_next;
    end
  end

  // Next state: kill abandons START/BUSY; in BUSY the unit's ready beats the
  // watchdog, which substitutes a zero result flagged as an exception.
  always_comb begin
    state_next = state_reg;
    cap_next   = cap_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          state_next = S_START;
        end
      end
      S_START: begin
        // Ready is deliberately ignored here: it may be left over from a
        // previous, abandoned operation.
        state_next = kill ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        if (kill) begin
          state_next = S_IDLE;
        end else if (md_resultRDY) begin
          state_next    = S_DONE;
          cap_next.data = md_result;
          cap_next.exc  = md_exception;
        end else if (wd_expired) begin
          state_next    = S_DONE;
          cap_next.data = '0;
          cap_next.exc  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign md_ctrl_MULT = in_start & (op_q == OP_MULT);
  assign md_ctrl_DIV  = in_start & (op_q == OP_DIV);

  // Stall drops in DONE so the dependent instruction issues right after
  // writeback; a request waiting in DONE is only seen once back in IDLE.
  assign stall = accept | in_start | in_busy;

  // Writes to r0 are suppressed unless they carry an exception.
  assign wb_fire      = in_done & ((rd_q != 5'd0) | cap_reg.exc);
  assign wb_valid     = wb_fire;
  assign wb_rd        = wb_fire ? rd_q : 5'd0;
  assign wb_data      = wb_fire ? cap_reg.data : 32'd0;
  assign wb_exception = wb_fire & cap_reg.exc;

endmodule
